// File: rtl/l2_burst_adaptor_pkg.sv
// Shared types for the L2 pmem burst adaptor: FSM state encoding used by the
// adaptor and visible to the L2-side mux-select packages.
package l2_burst_adaptor_types;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_BURST = 3'd1,
    RD_DONE  = 3'd2,
    WR_BURST = 3'd3,
    WR_DONE  = 3'd4
  } adaptor_state_t;

endpackage

// File: rtl/l2_burst_adaptor.sv
// Memory-side end of the L2 pmem interface: turns whole-line read/write requests
// into fixed-length bursts of memory beats and reassembles fill lines.
module l2_burst_adaptor
  import l2_burst_adaptor_types::*;
#(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  input  logic [ADDR_WIDTH-1:0]  address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  output logic                   resp_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  output logic [BURST_WIDTH-1:0] burst_o,
  output logic [ADDR_WIDTH-1:0]  address_o,
  output logic                   read_o,
  output logic                   write_o,
  input  logic                   resp_i
);

  localparam int BEATS = LINE_WIDTH / BURST_WIDTH;
  localparam int OFFS  = $clog2(LINE_WIDTH / 8);
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    {{(ADDR_WIDTH-OFFS){1'b1}}, {OFFS{1'b0}}};

  adaptor_state_t          r_state;
  adaptor_state_t          w_next_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [LINE_WIDTH-1:0]   r_wline;
  logic [LINE_WIDTH-1:0]   r_fill;
  logic [LINE_WIDTH-1:0]   r_line_o;
  logic [LINE_WIDTH-1:0]   w_fill_next;
  logic                    r_read;
  logic                    r_write;
  logic                    r_resp;
  logic                    w_in_burst;
  logic                    w_last_ack;
  logic                    w_accept;

  assign w_in_burst = (r_state == RD_BURST) || (r_state == WR_BURST);
  assign w_last_ack = w_in_burst && resp_i && (r_cnt == LAST_BEAT);
  assign w_accept   = (r_state == IDLE) && (read_i || write_i);

  // Next-state decode; write has priority so an eviction always precedes its fill.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (write_i) begin
          w_next_state = WR_BURST;
        end else if (read_i) begin
          w_next_state = RD_BURST;
        end else begin
          w_next_state = IDLE;
        end
      end
      RD_BURST: begin
        if (w_last_ack) begin
          w_next_state = RD_DONE;
        end else begin
          w_next_state = RD_BURST;
        end
      end
      RD_DONE:  w_next_state = IDLE;
      WR_BURST: begin
        if (w_last_ack) begin
          w_next_state = WR_DONE;
        end else begin
          w_next_state = WR_BURST;
        end
      end
      WR_DONE:  w_next_state = IDLE;
      default:  w_next_state = IDLE;
    endcase
  end

  // Fill line with the current beat merged in, so the last beat can commit in one step.
  always_comb begin
    w_fill_next = r_fill;
    if ((r_state == RD_BURST) && resp_i) begin
      w_fill_next[int'(r_cnt)*BURST_WIDTH +: BURST_WIDTH] = burst_i;
    end else begin
      w_fill_next = r_fill;
    end
  end

  // State, beat counter and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= {CNT_W{1'b0}};
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_resp  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_read  <= (w_next_state == RD_BURST);
      r_write <= (w_next_state == WR_BURST);
      r_resp  <= (w_next_state == RD_DONE) || (w_next_state == WR_DONE);
      if (w_in_burst && resp_i) begin
        r_cnt <= w_last_ack ? {CNT_W{1'b0}} : r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  // Request capture plus fill assembly; line_o only moves when a whole fill lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr   <= {ADDR_WIDTH{1'b0}};
      r_wline  <= {LINE_WIDTH{1'b0}};
      r_fill   <= {LINE_WIDTH{1'b0}};
      r_line_o <= {LINE_WIDTH{1'b0}};
    end else begin
      if (w_accept) begin
        r_addr <= address_i & LINE_MASK;
      end else begin
        r_addr <= r_addr;
      end
      if (w_accept && write_i) begin
        r_wline <= line_i;
      end else begin
        r_wline <= r_wline;
      end
      r_fill <= w_fill_next;
      if ((r_state == RD_BURST) && w_last_ack) begin
        r_line_o <= w_fill_next;
      end else begin
        r_line_o <= r_line_o;
      end
    end
  end

  assign burst_o   = r_write ? r_wline[int'(r_cnt)*BURST_WIDTH +: BURST_WIDTH]
                             : {BURST_WIDTH{1'b0}};
  assign line_o    = r_line_o;
  assign address_o = r_addr;
  assign read_o    = r_read;
  assign write_o   = r_write;
  assign resp_o    = r_resp;

endmodule

// File: tb/tb_l2_burst_adaptor.sv
// Randomised bench for l2_burst_adaptor: a behavioural memory/L2 model drives
// requests and beats and predicts every line, beat and handshake.
module tb_l2_burst_adaptor;

  logic         clk;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int n_checks = 0;
  int n_pass   = 0;
  logic [255:0] last_fill = 256'd0;
  bit ack_pat[$];

  l2_burst_adaptor dut (
    .clk(clk), .rst(rst), .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // One L2 transaction from request to resp_o; the memory side is modelled inline.
  task automatic run_txn(input bit do_rd, input bit do_wr, input logic [31:0] addr,
                         input logic [255:0] wline, input logic [255:0] rline,
                         input int gap_pct, input bit use_pat, input bit drop_early,
                         input bit check_lat);
    bit is_wr = do_wr;
    int beat = 0;
    int k = 0;
    int hi_cycles = 0;
    bit done = 0;
    bit ack;
    logic [31:0] exp_addr = addr & 32'hFFFF_FFE0;
    read_i = do_rd; write_i = do_wr; address_i = addr; line_i = wline; resp_i = 1'b0;
    while (!done && k < 300) begin
      @(posedge clk);
      @(negedge clk);
      k++;
      if (drop_early && beat >= 1) read_i = 1'b0;
      if (resp_o) begin
        check("beats_before_resp", 256'(beat), 256'd4);
        if (!is_wr) last_fill = rline;
        check("line_at_resp", line_o, last_fill);
        check("req_low_at_resp", {read_o, write_o}, 2'b00);
        if (check_lat) begin
          check("resp_cycle", 256'(k + 1), 256'd6);
          check("req_high_cycles", 256'(hi_cycles), 256'd4);
        end
        read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
        done = 1;
        @(negedge clk);
        check("resp_single_pulse", 256'(resp_o), 256'd0);
      end else begin
        check("line_hold", line_o, last_fill);
        check("resp_on_time", 256'(beat == 4), 256'd0);
        check("req_level", {read_o, write_o},
              (beat < 4) ? (is_wr ? 2'b01 : 2'b10) : 2'b00);
        if (read_o || write_o) begin
          hi_cycles++;
          check("address_o", 256'(address_o), 256'(exp_addr));
          if (is_wr && beat < 4)
            check("burst_o", 256'(burst_o), 256'(wline[beat*64 +: 64]));
        end
        if (use_pat && ack_pat.size() > 0) ack = ack_pat.pop_front();
        else ack = ($urandom_range(99) >= gap_pct);
        if (beat >= 4 || !(read_o || write_o)) ack = 1'b0;
        burst_i = {$urandom, $urandom};
        if (ack && !is_wr) burst_i = rline[beat*64 +: 64];
        if (ack) beat++;
        resp_i = ack;
      end
    end
    check("txn_completed", 256'(done), 256'd1);
  endtask

  initial begin
    logic [255:0] l;
    rst = 1'b1; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    address_i = 32'd0; line_i = 256'd0; burst_i = 64'd0;
    #1;
    check("rst_outputs", {resp_o, read_o, write_o, address_o, burst_o}, 256'd0);
    check("rst_line_o", line_o, 256'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed read, ack every cycle.
    l = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    run_txn(1'b1, 1'b0, 32'h0000_1040, 256'd0, l, 0, 1'b0, 1'b0, 1'b1);
    check("line_o_beat_order", line_o, l);

    // Directed write with unaligned address.
    l = rand_line();
    l[63:0] = 64'hAA; l[127:64] = 64'hBB; l[191:128] = 64'hCC; l[255:192] = 64'hDD;
    run_txn(1'b0, 1'b1, 32'h1234_567F, l, 256'd0, 0, 1'b0, 1'b0, 1'b1);

    // Read with ack gaps.
    ack_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    run_txn(1'b1, 1'b0, 32'h0BAD_F00D, 256'd0, rand_line(), 0, 1'b1, 1'b0, 1'b0);

    // Read and write together: write first, then the re-requested read.
    run_txn(1'b1, 1'b1, 32'h0000_2000, rand_line(), 256'd0, 30, 1'b0, 1'b0, 1'b0);
    run_txn(1'b1, 1'b0, 32'h0000_2000, 256'd0, rand_line(), 30, 1'b0, 1'b0, 1'b0);

    // Reset after two beats of a read.
    read_i = 1'b1; address_i = 32'h0000_3000;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      resp_i = (i < 2);
      burst_i = {$urandom, $urandom};
    end
    resp_i = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_read_o", 256'(read_o), 256'd0);
    check("abort_line_o", line_o, 256'd0);
    check("abort_resp_o", 256'(resp_o), 256'd0);
    last_fill = 256'd0;
    read_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_abort_quiet", {resp_o, read_o, write_o}, 3'b000);
    end
    run_txn(1'b1, 1'b0, 32'h0000_3000, 256'd0, rand_line(), 0, 1'b0, 1'b0, 1'b0);

    // Spurious acks in IDLE, then a read dropped mid-burst.
    for (int i = 0; i < 4; i++) begin
      resp_i = 1'b1;
      burst_i = {$urandom, $urandom};
      @(negedge clk);
      check("idle_ignores_resp_i", {resp_o, read_o, write_o}, 3'b000);
      check("idle_line_hold", line_o, last_fill);
    end
    resp_i = 1'b0;
    run_txn(1'b1, 1'b0, 32'h0000_4020, 256'd0, rand_line(), 40, 1'b0, 1'b1, 1'b0);

    // Random mix of reads, writes and simultaneous requests.
    for (int t = 0; t < 40; t++) begin
      int kind = $urandom_range(2);
      run_txn(kind != 1, kind != 0, $urandom, rand_line(), rand_line(),
              $urandom_range(60), 1'b0, 1'b0, 1'b0);
      repeat ($urandom_range(2)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
